rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_arb_grant.sv | 40 ++++
 rtl/rom_arbiter.sv | 99 +++++++++
 tb/tb_rom_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM read arbiter.
package rom_arb_pkg;

   // Read sequence: grant/latch address, ROM access, capture data, ack pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CAPT = 2'd2,
      ACK  = 2'd3
   } state_e;

   localparam logic       P0       = 1'b0;
   localparam logic       P1       = 1'b1;
   localparam logic [7:0] RST_DATA = 8'hFF;

   // Address width for a ROM of kb KiB; a zero-size ROM still gets a 1-bit bus
   function automatic int unsigned addr_w(input int unsigned kb);
      return (kb * 1024 > 1) ? $clog2(kb * 1024) : 1;
   endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Grant selection between the two requesters.
// ROM_ARB_RR_EN defined : round-robin, simultaneous requests go to the port
//                         named by ptr.
// ROM_ARB_RR_EN undefined: fixed priority, port 0 wins; ptr is ignored.
module rom_arb_grant
   import rom_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic gnt_vld,
   output logic gnt_idx
);

`ifdef ROM_ARB_RR_EN
   // Round-robin choice: pointer breaks ties, a lone request always wins
   always_comb begin
      gnt_vld = req0 | req1;
      gnt_idx = P0;
      if (req0 && req1) begin
         gnt_idx = ptr;
      end else if (req1) begin
         gnt_idx = P1;
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ptr;

   // Fixed priority: port 0 first, port 1 only when port 0 is idle
   always_comb begin
      gnt_vld = req0 | req1;
      gnt_idx = P0;
      if (!req0 && req1) begin
         gnt_idx = P1;
      end
   end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a single-port, 1-cycle registered ROM.
// One read per 4 cycles: IDLE (grant) -> WAIT (ROM samples rom_a) ->
// CAPT (load rom_q, raise ack) -> ACK (ack pulse) -> IDLE.
// Feature macro ROM_ARB_RR_EN selects round-robin arbitration instead of
// fixed priority to port 0.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter  int unsigned KB = 0,
   localparam int unsigned AW = addr_w(KB)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] a0,
   input  logic [AW-1:0] a1,
   output logic          ack0,
   output logic          ack1,
   output logic [7:0]    q0,
   output logic [7:0]    q1,
   output logic [AW-1:0] rom_a,
   input  logic [7:0]    rom_q
);

   state_e state_q;
   logic   sel_q;
   logic   ptr_q;
   logic   gnt_vld;
   logic   gnt_idx;

`ifdef ROM_ARB_RR_EN
   // Round-robin pointer: after each grant it points at the other port
   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_q <= P0;
      end else if (state_q == IDLE && gnt_vld) begin
         ptr_q <= ~gnt_idx;
      end
   end
`else
   assign ptr_q = P0;
`endif

   rom_arb_grant u_grant (
      .req0    (req0),
      .req1    (req1),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // Read sequencer with registered address, data and ack outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         sel_q   <= P0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         q0      <= RST_DATA;
         q1      <= RST_DATA;
         rom_a   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  rom_a   <= (gnt_idx == P1) ? a1 : a0;
                  sel_q   <= gnt_idx;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               state_q <= CAPT;
            end
            CAPT: begin
               if (sel_q == P1) begin
                  q1   <= rom_q;
                  ack1 <= 1'b1;
               end else begin
                  q0   <= rom_q;
                  ack0 <= 1'b1;
               end
               state_q <= ACK;
            end
            ACK: begin
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter (KB=16) with a 1-cycle registered ROM.
// Expected behaviour follows ROM_ARB_RR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rom_arbiter;

   localparam int unsigned KB    = 16;
   localparam int unsigned AW    = 14;
   localparam int unsigned DEPTH = KB * 1024;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req0  = 1'b0;
   logic          req1  = 1'b0;
   logic [AW-1:0] a0    = '0;
   logic [AW-1:0] a1    = '0;
   logic          ack0, ack1;
   logic [7:0]    q0, q1;
   logic [AW-1:0] rom_a;
   logic [7:0]    rom_q;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   rom_arbiter #(.KB(KB)) dut (
      .clock (clock),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .a0    (a0),
      .a1    (a1),
      .ack0  (ack0),
      .ack1  (ack1),
      .q0    (q0),
      .q1    (q1),
      .rom_a (rom_a),
      .rom_q (rom_q)
   );

   // ROM: registered read, data one clock after the address is sampled
   logic [7:0] mem [DEPTH];
   always @(posedge clock) rom_q <= mem[rom_a];

   // ---------------- transaction-level reference model ----------------
   // A read occupies the arbiter for 4 clocks from the grant edge; the data
   // and ack appear two edges after the grant and ack drops one edge later.
   int            m_busy = 0;
   logic          m_port = 1'b0;
   logic          m_ptr  = 1'b0;
   logic [7:0]    m_data = 8'h00;
   logic          m_ack0 = 1'b0, m_ack1 = 1'b0;
   logic [7:0]    m_q0 = 8'hFF, m_q1 = 8'hFF;
   logic [AW-1:0] m_rom_a = '0;

   function automatic logic pick_port(input logic r0, input logic r1, input logic ptr);
`ifdef ROM_ARB_RR_EN
      if (r0 && r1) return ptr;
`else
      if (r0 && r1) return 1'b0;
`endif
      return r1 ? 1'b1 : 1'b0;
   endfunction

   always @(posedge clock) begin
      if (!reset) begin
         m_busy  <= 0;
         m_ptr   <= 1'b0;
         m_ack0  <= 1'b0;
         m_ack1  <= 1'b0;
         m_q0    <= 8'hFF;
         m_q1    <= 8'hFF;
         m_rom_a <= '0;
      end else if (m_busy == 0) begin
         m_ack0 <= 1'b0;
         m_ack1 <= 1'b0;
         if (req0 || req1) begin
            m_port  <= pick_port(req0, req1, m_ptr);
            m_rom_a <= pick_port(req0, req1, m_ptr) ? a1 : a0;
            m_data  <= mem[pick_port(req0, req1, m_ptr) ? a1 : a0];
            m_ptr   <= ~pick_port(req0, req1, m_ptr);
            m_busy  <= 3;
         end
      end else begin
         m_busy <= m_busy - 1;
         if (m_busy == 2) begin
            if (m_port) begin m_q1 <= m_data; m_ack1 <= 1'b1; end
            else        begin m_q0 <= m_data; m_ack0 <= 1'b1; end
         end else begin
            m_ack0 <= 1'b0;
            m_ack1 <= 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers (no checking inside) ----------------
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Number of edges until the port's ack is seen, -1 if none within limit
   task automatic wait_ack(input logic port, input int limit, output int edges);
      edges = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if ((port ? ack1 : ack0) === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   // Both ports request together; each drops its request on its own ack
   task automatic run_pair(output int t0, output int t1);
      t0 = -1; t1 = -1;
      req0 = 1'b1; a0 = 14'h0010;
      req1 = 1'b1; a1 = 14'h0020;
      for (int i = 1; i <= 20 && (t0 < 0 || t1 < 0); i++) begin
         step();
         if (ack0 === 1'b1 && t0 < 0) begin t0 = i; req0 = 1'b0; end
         if (ack1 === 1'b1 && t1 < 0) begin t1 = i; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [AW+17:0] obs;
      reset = 1'b0;
      req0 = 1'b1; a0 = 14'h0155;
      req1 = 1'b1; a1 = 14'h0AAA;
      repeat (3) step();
      obs = {ack0, ack1, q0, q1, rom_a};
      checks++;
      if (obs !== {1'b0, 1'b0, 8'hFF, 8'hFF, 14'h0000}) begin
         errors++;
         $display("FAIL reset_state: got ack=%b%b q0=%h q1=%h rom_a=%h expected ack=00 q0=ff q1=ff rom_a=0000",
                  ack0, ack1, q0, q1, rom_a);
      end
      req0 = 1'b0; req1 = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      int e;
      req0 = 1'b1; a0 = 14'h1234;
      wait_ack(1'b0, 10, e);
      checks++;
      if (e !== 3) begin errors++; $display("FAIL single_latency: got %0d edges expected 3", e); end
      checks++;
      if (q0 !== 8'hA5) begin errors++; $display("FAIL single_q0: got %h expected a5", q0); end
      checks++;
      if (q1 !== 8'hFF) begin errors++; $display("FAIL single_q1_hold: got %h expected ff", q1); end
      req0 = 1'b0;
      step();
      checks++;
      if (ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0", ack0); end
      for (int i = 0; i < 3; i++) begin
         a0 = AW'($urandom);
         step();
         checks++;
         if (rom_a !== 14'h1234) begin errors++; $display("FAIL idle_rom_a_hold: got %h expected 1234", rom_a); end
      end
   endtask

   task automatic test_address_change();
      int e;
      req1 = 1'b1; a1 = 14'h0100;
      step();
      checks++;
      if (rom_a !== 14'h0100) begin errors++; $display("FAIL addr_latched: got %h expected 0100", rom_a); end
      a1 = 14'h0200;
      wait_ack(1'b1, 6, e);
      checks++;
      if (e !== 2) begin errors++; $display("FAIL addr_latency: got %0d edges expected 2 after change", e); end
      checks++;
      if (q1 !== 8'h5A) begin errors++; $display("FAIL addr_q1: got %h expected 5a", q1); end
      checks++;
      if (q0 !== 8'hA5) begin errors++; $display("FAIL addr_q0_hold: got %h expected a5", q0); end
      checks++;
      if (rom_a !== 14'h0100) begin errors++; $display("FAIL addr_rom_a_hold: got %h expected 0100", rom_a); end
      req1 = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      int t0, t1, e;
      run_pair(t0, t1);
      checks++;
      if (t0 !== 3 || t1 !== 7) begin
         errors++;
         $display("FAIL pair1_order: got ack0@%0d ack1@%0d expected ack0@3 ack1@7", t0, t1);
      end
      checks++;
      if (q0 !== 8'h11 || q1 !== 8'h22) begin
         errors++;
         $display("FAIL pair1_data: got q0=%h q1=%h expected q0=11 q1=22", q0, q1);
      end
      // A lone port-0 read moves the round-robin pointer to port 1
      req0 = 1'b1; a0 = 14'h1234;
      wait_ack(1'b0, 10, e);
      checks++;
      if (e !== 3 || q0 !== 8'hA5) begin
         errors++;
         $display("FAIL mid_single: got %0d edges q0=%h expected 3 edges q0=a5", e, q0);
      end
      req0 = 1'b0;
      step();
      run_pair(t0, t1);
`ifdef ROM_ARB_RR_EN
      checks++;
      if (t1 !== 3 || t0 !== 7) begin
         errors++;
         $display("FAIL pair2_order_rr: got ack0@%0d ack1@%0d expected ack1@3 ack0@7", t0, t1);
      end
`else
      checks++;
      if (t0 !== 3 || t1 !== 7) begin
         errors++;
         $display("FAIL pair2_order_fixed: got ack0@%0d ack1@%0d expected ack0@3 ack1@7", t0, t1);
      end
`endif
      checks++;
      if (q0 !== 8'h11 || q1 !== 8'h22) begin
         errors++;
         $display("FAIL pair2_data: got q0=%h q1=%h expected q0=11 q1=22", q0, q1);
      end
   endtask

   task automatic test_dropped_req();
      int e;
      req0 = 1'b1; a0 = 14'h0040;
      step();
      req0 = 1'b0;
      wait_ack(1'b0, 6, e);
      checks++;
      if (e !== 2) begin errors++; $display("FAIL drop_ack: got %0d edges expected 2 after drop", e); end
      checks++;
      if (q0 !== mem[14'h0040]) begin errors++; $display("FAIL drop_q0: got %h expected %h", q0, mem[14'h0040]); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0 || rom_a !== 14'h0040) begin
            errors++;
            $display("FAIL drop_idle: got ack=%b%b rom_a=%h expected ack=00 rom_a=0040", ack0, ack1, rom_a);
         end
      end
   endtask

   task automatic test_starvation();
      int e, n0;
      logic seen1;
      req0 = 1'b1; a0 = 14'h0010;
      repeat (2) step();
      req1 = 1'b1; a1 = 14'h0020;
`ifdef ROM_ARB_RR_EN
      wait_ack(1'b1, 8, e);
      checks++;
      if (e < 0) begin errors++; $display("FAIL starve_rr: got no ack1 expected ack1 within 8 cycles"); end
      checks++;
      if (q1 !== 8'h22) begin errors++; $display("FAIL starve_rr_q1: got %h expected 22", q1); end
      req1 = 1'b0;
`else
      seen1 = 1'b0; n0 = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack1 === 1'b1) seen1 = 1'b1;
         if (ack0 === 1'b1) n0++;
      end
      checks++;
      if (seen1 !== 1'b0) begin errors++; $display("FAIL starve_fixed: got ack1 expected none while req0 high"); end
      checks++;
      if (n0 < 4) begin errors++; $display("FAIL starve_fixed_p0: got %0d port0 acks expected at least 4", n0); end
      req0 = 1'b0;
      wait_ack(1'b1, 10, e);
      checks++;
      if (e < 0 || q1 !== 8'h22) begin
         errors++;
         $display("FAIL starve_fixed_release: got edges=%0d q1=%h expected ack1 with q1=22", e, q1);
      end
      req1 = 1'b0;
`endif
      req0 = 1'b0;
      repeat (6) step();
   endtask

   task automatic test_reset_midop();
      int e;
      req0 = 1'b1; a0 = 14'h0080;
      repeat (2) step();
      reset = 1'b0; req0 = 1'b0;
      step();
      checks++;
      if ({ack0, ack1, q0, q1, rom_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF, 14'h0000}) begin
         errors++;
         $display("FAIL midop_reset: got ack=%b%b q0=%h q1=%h rom_a=%h expected ack=00 q0=ff q1=ff rom_a=0000",
                  ack0, ack1, q0, q1, rom_a);
      end
      step();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_ack: got ack=%b%b expected 00", ack0, ack1);
         end
      end
      req0 = 1'b1; a0 = 14'h1234;
      wait_ack(1'b0, 10, e);
      checks++;
      if (e !== 3 || q0 !== 8'hA5) begin
         errors++;
         $display("FAIL midop_next: got %0d edges q0=%h expected 3 edges q0=a5", e, q0);
      end
      req0 = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         step();
         checks++;
         if ({ack0, ack1, q0, q1, rom_a} !== {m_ack0, m_ack1, m_q0, m_q1, m_rom_a}) begin
            errors++;
            $display("FAIL random_cycle_%0d: got ack=%b%b q0=%h q1=%h rom_a=%h expected ack=%b%b q0=%h q1=%h rom_a=%h",
                     i, ack0, ack1, q0, q1, rom_a, m_ack0, m_ack1, m_q0, m_q1, m_rom_a);
         end
         reset = ($urandom_range(0, 199) != 0);
         if (req0 && ack0) req0 = 1'b0;
         else if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; a0 = AW'($urandom); end
         else if (req0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
         if (req1 && ack1) req1 = 1'b0;
         else if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; a1 = AW'($urandom); end
         else if (req1 && $urandom_range(0, 15) == 0) req1 = 1'b0;
         if ($urandom_range(0, 3) == 0) a0 = AW'($urandom);
         if ($urandom_range(0, 3) == 0) a1 = AW'($urandom);
      end
      req0 = 1'b0; req1 = 1'b0; reset = 1'b1;
      repeat (6) step();
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);
      mem[14'h1234] = 8'hA5;
      mem[14'h0010] = 8'h11;
      mem[14'h0020] = 8'h22;
      mem[14'h0100] = 8'h5A;
      mem[14'h0200] = 8'hC3;
      @(negedge clock);
      test_reset();
      test_single_read();
      test_address_change();
      test_simultaneous();
      test_dropped_req();
      test_starvation();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
